// File: rtl/fifo_top_module.sv
// Single-clock FIFO with registered read data and pointer-decoded full/empty flags.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module fifo_top_module #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full_flag,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_flag
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  do_write;
  logic                  do_read;

  assign empty_flag = (wptr == rptr);
  assign full_flag  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                      (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  // Both requests are qualified against the flags as they stand before the edge.
  assign do_write = i_wen & ~full_flag;
  assign do_read  = i_ren & ~empty_flag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
    end else begin
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
      if (do_read) begin
        data_out <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr     <= rptr + 1'b1;
      end
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge i_clk) begin
    if (!i_rst && do_write) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_top_module.sv
// Scoreboard bench for fifo_top_module: stimulus pushes expected read data,
// a monitor pops and compares whenever an accepted read completes.
module tb_fifo_top_module;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wen = 1'b1;
  logic       i_ren = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_out;
  logic       full_flag;
  logic       empty_flag;

  fifo_top_module #(.DATA_WIDTH(4), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wen      (i_wen),
    .data_in    (data_in),
    .full_flag  (full_flag),
    .i_ren      (i_ren),
    .data_out   (data_out),
    .empty_flag (empty_flag)
  );

  always #5 i_clk = ~i_clk;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_q [$];
  logic [3:0] exp_q [$];
  logic [3:0] last_exp = 4'h0;
  logic       rd_strobe = 1'b0;
  logic       rst_strobe = 1'b1;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after every edge, data_out is either the popped word, zero after reset, or held.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rst_strobe) begin
        last_exp = 4'h0;
        check_val("reset_data_out", int'(data_out), 0);
      end else if (rd_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_scoreboard: got %0h expected nothing queued", data_out);
        end else begin
          last_exp = exp_q.pop_front();
          check_val("rd_data", int'(data_out), int'(last_exp));
        end
      end else begin
        check_val("hold_data_out", int'(data_out), int'(last_exp));
      end
    end
  end

  task automatic check_flags();
    check_val("empty_flag", int'(empty_flag), int'(model_q.size() == 0));
    check_val("full_flag", int'(full_flag), int'(model_q.size() == 8));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [3:0] d);
    logic wacc;
    logic racc;
    @(negedge i_clk);
    check_flags();
    wacc = w && (model_q.size() < 8);
    racc = r && (model_q.size() > 0);
    i_rst      = 1'b0;
    i_wen      = w;
    i_ren      = r;
    data_in    = d;
    rst_strobe = 1'b0;
    rd_strobe  = racc;
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
  endtask

  task automatic rst_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      check_flags();
      i_rst      = 1'b1;
      i_wen      = 1'b1;
      i_ren      = 1'b1;
      data_in    = 4'hF;
      rd_strobe  = 1'b0;
      rst_strobe = 1'b1;
      model_q.delete();
    end
    cycle(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] v;
    rst_cycles(10);

    // Fill past capacity: 12 pulses, the last 4 see full and are dropped.
    for (int i = 0; i < 12; i++) begin
      v = 4'(i);
      cycle(1'b1, 1'b0, v);
      cycle(1'b0, 1'b0, 4'h0);
    end

    // Drain with 15 attempts; the last 7 see empty and data_out holds 0x7.
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b1, 4'h0);
      cycle(1'b0, 1'b0, 4'h0);
    end

    // Wrap-around: write 5 / read 5, three times, data 0x0..0xE.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 5; i++) begin
        v = 4'(rep * 5 + i);
        cycle(1'b1, 1'b0, v);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'h0);
    end

    // Simultaneous access with 3 words stored.
    for (int i = 0; i < 3; i++) begin
      v = 4'(4'h9 + i);
      cycle(1'b1, 1'b0, v);
    end
    for (int i = 0; i < 10; i++) begin
      v = 4'(i + 3);
      cycle(1'b1, 1'b1, v);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h0);

    // From empty: only the write happens.
    cycle(1'b1, 1'b1, 4'hC);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 4'h0);

    // From full: only the read happens and full drops.
    for (int i = 0; i < 8; i++) begin
      v = 4'(15 - i);
      cycle(1'b1, 1'b0, v);
    end
    cycle(1'b1, 1'b1, 4'h5);
    cycle(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 4'h0);

    // Mid-operation reset with 5 words stored.
    for (int i = 0; i < 5; i++) begin
      v = 4'(i + 1);
      cycle(1'b1, 1'b0, v);
    end
    rst_cycles(1);
    cycle(1'b1, 1'b0, 4'hA);
    cycle(1'b0, 1'b1, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);

    @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
